// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard code path: PS/2 prefix bytes,
// prefix-decoder state encoding and the stored entry width {ext, brk, code}.
package kbd_pkg;

    localparam int KBD_DATA_W = 8;
    localparam logic [7:0] KBD_EXT = 8'hE0;
    localparam logic [7:0] KBD_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } kbd_state_t;

    // Entry width: the code plus the extended and break flags.
    function automatic int entry_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/kbd_fifo_mem.sv
// FWFT FIFO storage: sync write, async read of the head, registered occupancy.
// Latency: pushed word is visible at the head the cycle after the write edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module kbd_fifo_mem #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] cuenta,
    output logic                       vacio,
    output logic                       lleno
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && !vacio;
    assign do_push = push && (!lleno || do_pop);

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cuenta <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cuenta <= cuenta + 1'b1;
            else if (do_pop && !do_push)
                cuenta <= cuenta - 1'b1;
        end
    end

    assign rdata = mem[rd_ptr];
    assign vacio = (cuenta == '0);
    assign lleno = (cuenta == CW'(DEPTH));

endmodule

// File: rtl/reg_datos_fifo.sv
// Decodes PS/2 E0/F0 prefixes into per-entry flags and buffers codes in a FWFT FIFO.
// Latency: a code accepted at edge N is at the head from cycle N+1.
// Backpressure: none upstream; codes arriving when full are dropped and flag sticky ovf.
module reg_datos_fifo
    import kbd_pkg::*;
#(
    parameter int DATA_W       = KBD_DATA_W,
    parameter int DEPTH        = 8,
    parameter bit PREFIX_EN    = 1'b1,
    parameter bit FILTER_BREAK = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          dato,
    input  logic                       EN,
    input  logic                       rd,
    input  logic                       clr_ovf,
    output logic [DATA_W-1:0]          dato_out,
    output logic                       ext_out,
    output logic                       brk_out,
    output logic                       vacio,
    output logic                       lleno,
    output logic [$clog2(DEPTH+1)-1:0] cuenta,
    output logic                       ovf
);
    localparam int EW = entry_w(DATA_W);

    kbd_state_t        state;
    kbd_state_t        state_nxt;
    logic              push_req;
    logic              push_ext;
    logic              push_brk;
    logic              is_ext;
    logic              is_brk;
    logic [EW-1:0]     head;

    assign is_ext = (dato == DATA_W'(KBD_EXT));
    assign is_brk = (dato == DATA_W'(KBD_BRK));

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        if (EN) begin
            if (!PREFIX_EN) begin
                push_req = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_ext)      state_nxt = GOT_E0;
                        else if (is_brk) state_nxt = GOT_F0;
                        else             push_req  = 1'b1;
                    end
                    GOT_E0: begin
                        if (is_brk) state_nxt = GOT_E0F0;
                        else if (!is_ext) begin
                            push_req  = 1'b1;
                            push_ext  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    GOT_F0: begin
                        if (is_ext) state_nxt = GOT_E0F0;
                        else if (!is_brk) begin
                            push_req  = !FILTER_BREAK;
                            push_brk  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    default: begin
                        if (!is_ext && !is_brk) begin
                            push_req  = !FILTER_BREAK;
                            push_ext  = 1'b1;
                            push_brk  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Full implies non-empty, so rd alone tells whether the slot frees up this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push_req && lleno && !rd) ovf <= 1'b1;
            else if (clr_ovf)             ovf <= 1'b0;
        end
    end

    kbd_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .rst    (rst),
        .push   (push_req),
        .pop    (rd),
        .wdata  ({push_ext, push_brk, dato}),
        .rdata  (head),
        .cuenta (cuenta),
        .vacio  (vacio),
        .lleno  (lleno)
    );

    assign dato_out = vacio ? '0 : head[DATA_W-1:0];
    assign ext_out  = !vacio && head[DATA_W+1];
    assign brk_out  = !vacio && head[DATA_W];

endmodule

// File: tb/tb_reg_datos_fifo.sv
// Bench for reg_datos_fifo: default build and a break-filtering build share stimulus,
// each checked against a queue-based model of the keyboard code buffer.
module tb_reg_datos_fifo;
    import kbd_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, EN, rd, clr_ovf;
    logic [7:0] dato;

    logic [7:0] dato_out0, dato_out1;
    logic       ext0, ext1, brk0, brk1, vacio0, vacio1, lleno0, lleno1, ovf0, ovf1;
    logic [3:0] cuenta0, cuenta1;

    int checks = 0;
    int errors = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    bit         m_ovf0, m_ovf1;
    bit         pend_ext, pend_brk;

    always #5 clk = ~clk;

    reg_datos_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dato(dato), .EN(EN), .rd(rd), .clr_ovf(clr_ovf),
        .dato_out(dato_out0), .ext_out(ext0), .brk_out(brk0), .vacio(vacio0),
        .lleno(lleno0), .cuenta(cuenta0), .ovf(ovf0)
    );

    reg_datos_fifo #(.DEPTH(DEPTH), .FILTER_BREAK(1'b1)) dut_f (
        .clk(clk), .rst(rst), .dato(dato), .EN(EN), .rd(rd), .clr_ovf(clr_ovf),
        .dato_out(dato_out1), .ext_out(ext1), .brk_out(brk1), .vacio(vacio1),
        .lleno(lleno1), .cuenta(cuenta1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: pending prefixes are just two sticky bits until a real code arrives.
    task automatic model_edge(input logic r, input logic en, input logic [7:0] d,
                              input logic rdi, input logic clr);
        bit want0, want1, pop0, pop1, set0, set1;
        logic [9:0] ent;
        if (!r) begin
            q0.delete(); q1.delete();
            m_ovf0 = 0; m_ovf1 = 0; pend_ext = 0; pend_brk = 0;
            return;
        end
        want0 = 0; want1 = 0;
        ent = {pend_ext, pend_brk, d};
        if (en) begin
            if (d == KBD_EXT)      pend_ext = 1;
            else if (d == KBD_BRK) pend_brk = 1;
            else begin
                want0 = 1;
                want1 = !ent[8];
                pend_ext = 0; pend_brk = 0;
            end
        end
        pop0 = rdi && q0.size() > 0;
        pop1 = rdi && q1.size() > 0;
        set0 = want0 && q0.size() == DEPTH && !pop0;
        set1 = want1 && q1.size() == DEPTH && !pop1;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (want0 && !set0) q0.push_back(ent);
        if (want1 && !set1) q1.push_back(ent);
        m_ovf0 = set0 ? 1'b1 : (clr ? 1'b0 : m_ovf0);
        m_ovf1 = set1 ? 1'b1 : (clr ? 1'b0 : m_ovf1);
    endtask

    task automatic check_all();
        logic [9:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 10'h0;
        h1 = (q1.size() > 0) ? q1[0] : 10'h0;
        chk("dato0",   dato_out0, h0[7:0]);
        chk("ext0",    ext0,      h0[9]);
        chk("brk0",    brk0,      h0[8]);
        chk("cuenta0", cuenta0,   q0.size());
        chk("vacio0",  vacio0,    q0.size() == 0);
        chk("lleno0",  lleno0,    q0.size() == DEPTH);
        chk("ovf0",    ovf0,      m_ovf0);
        chk("dato1",   dato_out1, h1[7:0]);
        chk("ext1",    ext1,      h1[9]);
        chk("brk1",    brk1,      h1[8]);
        chk("cuenta1", cuenta1,   q1.size());
        chk("vacio1",  vacio1,    q1.size() == 0);
        chk("lleno1",  lleno1,    q1.size() == DEPTH);
        chk("ovf1",    ovf1,      m_ovf1);
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] d,
                        input logic rdi, input logic clr);
        rst = r; EN = en; dato = d; rd = rdi; clr_ovf = clr;
        @(posedge clk);
        model_edge(r, en, d, rdi, clr);
        #1;
        rst = 1'b1; EN = 1'b0; dato = 8'h00; rd = 1'b0; clr_ovf = 1'b0;
        check_all();
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b0; EN = 1'b0; dato = 8'h00; rd = 1'b0; clr_ovf = 1'b0;
        #2;

        // Reset state
        step(1'b0, 0, 8'h00, 0, 0);
        chk("rst_vacio", vacio0, 1'b1);
        chk("rst_cuenta", cuenta0, 4'd0);

        // Single make code, then pop back to empty
        step(1, 1, 8'h1C, 0, 0);
        chk("tp1_dato", dato_out0, 8'h1C);
        chk("tp1_cuenta", cuenta0, 4'd1);
        step(1, 0, 8'h00, 1, 0);
        chk("tp1_empty", {vacio0, dato_out0}, {1'b1, 8'h00});

        // Extended break: E0 F0 74
        step(1, 1, KBD_EXT, 0, 0);
        step(1, 1, KBD_BRK, 0, 0);
        chk("tp2_noprefix", cuenta0, 4'd0);
        step(1, 1, 8'h74, 0, 0);
        chk("tp2_entry", {ext0, brk0, dato_out0, cuenta0}, {1'b1, 1'b1, 8'h74, 4'd1});
        chk("tp2_filtered", cuenta1, 4'd0);
        step(1, 0, 8'h00, 1, 0);

        // Make, break of same key: filtered build keeps only the make
        step(1, 1, 8'h1C, 0, 0);
        step(1, 1, KBD_BRK, 0, 0);
        step(1, 1, 8'h1C, 0, 0);
        chk("tp3_filt_cnt", cuenta1, 4'd1);
        chk("tp3_filt_head", {brk1, dato_out1}, {1'b0, 8'h1C});
        chk("tp3_raw_cnt", cuenta0, 4'd2);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 0);

        // Overflow: nine codes into eight slots
        for (int i = 1; i <= 9; i++) step(1, 1, 8'(i), 0, 0);
        chk("tp4_full", {lleno0, cuenta0, ovf0}, {1'b1, 4'd8, 1'b1});
        for (int i = 1; i <= 8; i++) begin
            chk("tp4_order", dato_out0, 8'(i));
            step(1, 0, 8'h00, 1, 0);
        end
        step(1, 0, 8'h00, 0, 1);
        chk("tp4_clr", ovf0, 1'b0);

        // Push and pop on a full FIFO
        for (int i = 1; i <= 8; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
        step(1, 1, 8'h2A, 1, 0);
        chk("tp5_cnt", {cuenta0, lleno0, ovf0}, {4'd8, 1'b1, 1'b0});
        for (int i = 0; i < 7; i++) step(1, 0, 8'h00, 1, 0);
        chk("tp5_last", dato_out0, 8'h2A);
        step(1, 0, 8'h00, 1, 0);

        // Reset discards a pending prefix; pop on empty is harmless
        step(1, 1, KBD_EXT, 0, 0);
        step(1'b0, 0, 8'h00, 0, 0);
        step(1, 1, 8'h5A, 0, 0);
        chk("tp6_entry", {ext0, dato_out0}, {1'b0, 8'h5A});
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 0);
        chk("tp6_empty", {vacio0, cuenta0}, {1'b1, 4'd0});

        // Random traffic, prefix-heavy byte mix
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = KBD_EXT;
                2, 3:    b = KBD_BRK;
                default: b = 8'($urandom);
            endcase
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), b,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_datos_fifo.md
Name: reg_datos_fifo

Overview:
- Parametrised successor to the single keyboard-code holding register.
- Sits between the PS/2 receiver and the consumer logic (display/control).
- Decodes the PS/2 prefix bytes (E0 extended, F0 break) into per-entry flags.
- Buffers DEPTH decoded codes in a first-word-fall-through FIFO, so bursts of scan codes are not lost while the consumer is busy.

Parameters:
- DATA_W, 8: code width in bits. Prefix decoding is only meaningful at 8.
- DEPTH, 8: FIFO entries; power of 2, ≥2.
- PREFIX_EN, 1: 1 = decode E0/F0 into flags; 0 = store every byte raw, with flags forced to 0.
- FILTER_BREAK, 0: when PREFIX_EN=1, 1 = discard break codes (only make codes are stored).

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-low reset, sampled on rising clk
- dato  in  DATA_W  byte from keyboard receiver
- EN  in  1  one-cycle strobe; dato valid this cycle
- rd  in  1  pop head entry
- clr_ovf  in  1  clear sticky overflow flag
- dato_out  out  DATA_W  head code (FWFT); 0 when empty
- ext_out  out  1  head entry extended flag; 0 when empty
- brk_out  out  1  head entry break flag; 0 when empty
- vacio  out  1  FIFO empty
- lleno  out  1  FIFO full
- cuenta  out  $clog2(DEPTH+1)  number of stored entries
- ovf  out  1  sticky: a code was dropped because the FIFO was full

Behaviour:
- Reset (rst=0 at a clk edge):
  - rd/wr pointers = 0, cuenta = 0, vacio = 1, lleno = 0, ovf = 0, prefix FSM = IDLE.
  - dato_out/ext_out/brk_out read 0.
  - Memory contents are not reset.
- Reset mid-operation discards all entries and any pending prefix.
- Prefix FSM (PREFIX_EN=1), evaluated only on EN=1. Prefix bytes are never stored.
  - IDLE: E0 → GOT_E0; F0 → GOT_F0; other → push {ext=0, brk=0, code}.
  - GOT_E0: F0 → GOT_E0F0; E0 → stay; other → push {1,0,code}, → IDLE.
  - GOT_F0: E0 → GOT_E0F0; F0 → stay; other → push {0,1,code} (no push if FILTER_BREAK=1), → IDLE.
  - GOT_E0F0: E0/F0 → stay; other → push {1,1,code} (no push if FILTER_BREAK=1), → IDLE.
- PREFIX_EN=0: every EN byte is pushed as {0,0,dato}.
- Push timing:
  - A push decided at edge N writes memory at edge N.
  - vacio falls and cuenta increments after edge N; head visible from cycle N+1.
- Pop:
  - rd=1 with vacio=0 advances rd_ptr at the edge; next head is visible the following cycle.
  - rd with vacio=1 is ignored; no underflow, pointers unchanged.
- Simultaneous push and pop:
  - Not empty: both occur, cuenta unchanged.
  - Empty: push only.
  - Full: pop and push both occur, lleno stays 1, no overflow.
- Push while full without pop: entry dropped, ovf set to 1, FSM still returns to IDLE.
- ovf clears only on clr_ovf=1 or reset. If set and clear coincide, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Flags:
  - vacio = (cuenta==0); lleno = (cuenta==DEPTH).
  - Both are derived from a registered cuenta, so they are glitch-free.

Decomposition:
- Package kbd_pkg holds:
  - constants KBD_EXT = 8'hE0 and KBD_BRK = 8'hF0;
  - the prefix-FSM state encoding (IDLE, GOT_E0, GOT_F0, GOT_E0F0, 2 bits);
  - the entry width constant DATA_W+2.
- Natural sub-module: kbd_fifo_mem, a generic synchronous-write, asynchronous-read FIFO storage with pointers, cuenta, vacio and lleno.
- Top level holds the prefix FSM and ovf logic.

Test Plan:
- Reset then EN with 8'h1C → after one cycle: vacio=0, dato_out=8'h1C, ext_out=0, brk_out=0, cuenta=1; rd → vacio=1, dato_out=0.
- Bytes E0, F0, 74 (FILTER_BREAK=0) → one entry: dato_out=8'h74, ext_out=1, brk_out=1; cuenta=1.
- FILTER_BREAK=1, bytes 1C, F0, 1C → only one entry (1C, brk=0); cuenta=1.
- DEPTH=8: push 9 codes 8'h01..8'h09 with no rd → lleno=1, cuenta=8, ovf=1; pop all reads 01..08 in order; clr_ovf → ovf=0.
- Full FIFO, EN (code 8'h2A) and rd in the same cycle → cuenta stays 8, ovf stays 0, 8'h2A read last.
- After E0 only, drive rst=0 for one edge, then byte 8'h5A → entry 5A with ext_out=0 (prefix discarded); rd while empty → no change.
